aes_round_ctrl: RTL

Round sequencer for the iterative AES-128 encryption path. It accepts one plaintext block per valid/ready handshake and runs the key generator through its expansion sweep by driving `round_index`. It then walks the data state through the initial AddRoundKey and NR rounds, fetching each round key via `round_index` and XORing it into the output of the external round function. It holds the ciphertext on a valid/ready output until it is consumed.

---
 rtl/aes_round_ctrl.sv | 81 ++++++++
 1 files changed

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: round sequencer for an iterative AES-128 encryption datapath
// Ports: clk/rst (async active-high); in_valid/in_ready/plaintext accept a block;
// round_index/key_expand drive the key generator, round_key returns its registered key;
// state_out/last_round feed the external round function, round_fn is its result;
// out_valid/out_ready/ciphertext hold the result until consumed.
module aes_round_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    output logic [3:0]   round_index,
    output logic         key_expand,
    input  logic [127:0] round_key,
    output logic [127:0] state_out,
    output logic         last_round,
    input  logic [127:0] round_fn,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext
);
    localparam logic [3:0] W_NR = 4'(NR);
    localparam logic [3:0] W_LAST_STEP = 4'(NR - 1);

    typedef enum logic [2:0] {IDLE, KEYGEN, FETCH, APPLY, DONE} state_t;

    state_t       r_state, w_next;
    logic [3:0]   r_step;
    logic [3:0]   r_round;
    logic [127:0] r_data;
    logic         w_rounds;

    assign w_rounds = (r_state == FETCH) || (r_state == APPLY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_step  <= '0;
            r_round <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: if (in_valid) begin
                    r_data  <= plaintext;
                    r_step  <= '0;
                    r_round <= '0;
                end
                KEYGEN: r_step <= r_step + 4'd1;
                // round 0 is the bare AddRoundKey; later rounds take the external function's result
                APPLY: begin
                    r_data <= (r_round == 4'd0 ? r_data : round_fn) ^ round_key;
                    if (r_round != W_NR) r_round <= r_round + 4'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = in_valid ? KEYGEN : IDLE;
            KEYGEN:  w_next = (r_step == W_LAST_STEP) ? FETCH : KEYGEN;
            FETCH:   w_next = APPLY;
            APPLY:   w_next = (r_round == W_NR) ? DONE : FETCH;
            DONE:    w_next = out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    assign in_ready    = r_state == IDLE;
    assign key_expand  = r_state == KEYGEN;
    assign out_valid   = r_state == DONE;
    assign round_index = key_expand ? r_step : w_rounds ? r_round : 4'd0;
    assign last_round  = w_rounds && (r_round == W_NR);
    assign state_out   = r_data;
    assign ciphertext  = r_data;
endmodule
